bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Sits directly upstream of the BCD-to-7-segment decoder.
- Each 4-bit digit of out_BCD drives one decoder instance, or one digit slot of a display scanner.
- Start/done handshake; result held stable between conversions.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_add3_digit.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared constants, state type and range helper for bin_to_bcd_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int          BCD_W       = 4;
   localparam logic [3:0]  ADD3_THRESH = 4'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Largest value representable in the given number of decimal digits.
   function automatic int unsigned max_val(input int unsigned digits);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < digits; i++) begin
         r = r * 10;
      end
      return r - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3_digit.sv
// ============================================================================
// bcd_add3_digit : double-dabble correction, adds 3 to a digit that is >= 5
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [3:0] in_digit,
   output logic [3:0] out_digit
);

   assign out_digit = (in_digit >= ADD3_THRESH) ? in_digit + 4'd3 : in_digit;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// bin_to_bcd_seq : sequential binary-to-BCD converter, one bit per clock.
// Optional BIN2BCD_SAT_EN saturates overflowing results to all 9s.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_start,
   input  logic [WIDTH-1:0]        in_BIN,
   output logic [BCD_W*DIGITS-1:0] out_BCD,
   output logic                    out_busy,
   output logic                    out_done,
   output logic                    out_ovf
);

   localparam int          SW      = BCD_W * (DIGITS + 1);
   localparam int          OW      = BCD_W * DIGITS;
   localparam int unsigned MAX_VAL = max_val(DIGITS);
   localparam int          CW      = 5;
   localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [SW-1:0]     scratch_q, scratch_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovf_next_q, ovf_next_d;
   logic [OW-1:0]     bcd_q, bcd_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic [SW-1:0]     add3_out;
   logic              unused_top_bit;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS + 1; gi++) begin : g_add3
         bcd_add3_digit u_add3 (
            .in_digit  (scratch_q[BCD_W*gi +: BCD_W]),
            .out_digit (add3_out[BCD_W*gi +: BCD_W])
         );
      end
   endgenerate

   // The spare top digit's MSB is shifted out; it only guards lower digits.
   assign unused_top_bit = add3_out[SW-1];

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_next_d = ovf_next_q;
      bcd_d      = bcd_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_start) begin
               bin_d      = in_BIN;
               scratch_d  = '0;
               ovf_next_d = (32'(in_BIN) > MAX_VAL);
               cnt_d      = '0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = {add3_out[SW-2:0], bin_q[WIDTH-1]};
            bin_d     = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
`ifdef BIN2BCD_SAT_EN
            bcd_d = ovf_next_q ? {DIGITS{4'd9}} : scratch_q[OW-1:0];
`else
            bcd_d = scratch_q[OW-1:0];
`endif
            ovf_d   = ovf_next_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_next_q <= 1'b0;
         bcd_q      <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_next_q <= ovf_next_d;
         bcd_q      <= bcd_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_BCD  = bcd_q;
   assign out_busy = (state_q != IDLE);
   assign out_done = done_q;
   assign out_ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// tb_bin_to_bcd_seq : self-checking bench, default instance plus a DIGITS=2 one
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;
   logic        in_start;
   logic [7:0]  in_bin;
   logic [11:0] bcd;
   logic        busy, done, ovf;

   logic        in_start2;
   logic [7:0]  in_bin2;
   logic [7:0]  bcd2;
   logic        busy2, done2, ovf2;

   int n_cmp = 0;
   int n_bad = 0;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk(clk), .rst(rst), .in_start(in_start), .in_BIN(in_bin),
      .out_BCD(bcd), .out_busy(busy), .out_done(done), .out_ovf(ovf)
   );

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst(rst), .in_start(in_start2), .in_BIN(in_bin2),
      .out_BCD(bcd2), .out_busy(busy2), .out_done(done2), .out_ovf(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits of v (mod 10**d, or all 9s when saturating).
   function automatic logic [19:0] ref_bcd(input int unsigned v, input int unsigned d);
      int unsigned lim;
      int unsigned x;
      logic [19:0] r;
      lim = 1;
      for (int unsigned i = 0; i < d; i++) lim = lim * 10;
      r = '0;
`ifdef BIN2BCD_SAT_EN
      if (v >= lim) begin
         for (int unsigned i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
         return r;
      end
`endif
      x = v % lim;
      for (int unsigned i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic convert1(input logic [7:0] v, input int inject_k);
      int busy_n, done_n, done_k;
      logic stable;
      logic [19:0] e20;
      logic [11:0] exp_bcd;
      e20 = ref_bcd(v, 3);
      exp_bcd = e20[11:0];
      @(negedge clk);
      in_start = 1'b1;
      in_bin   = v;
      @(negedge clk);
      in_start = 1'b0;
      busy_n = 0; done_n = 0; done_k = 0; stable = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         if (k > 1) @(negedge clk);
         if (busy) busy_n++;
         if (done) begin done_n++; done_k = k; end
         if (done_k != 0 && k > done_k && bcd !== exp_bcd) stable = 1'b0;
         if (k == inject_k) begin
            in_start = 1'b1;
            in_bin   = 8'd7;
         end else begin
            in_start = 1'b0;
         end
      end
      n_cmp++;
      if (done_n !== 1) begin n_bad++; $display("FAIL conv(%0d) done_count: got %0d want 1", v, done_n); end
      n_cmp++;
      if (done_k !== 10) begin n_bad++; $display("FAIL conv(%0d) latency: got %0d want 10", v, done_k); end
      n_cmp++;
      if (busy_n !== 9) begin n_bad++; $display("FAIL conv(%0d) busy_cycles: got %0d want 9", v, busy_n); end
      n_cmp++;
      if (bcd !== exp_bcd) begin n_bad++; $display("FAIL conv(%0d) bcd: got %h want %h", v, bcd, exp_bcd); end
      n_cmp++;
      if (ovf !== 1'b0) begin n_bad++; $display("FAIL conv(%0d) ovf: got %b want 0", v, ovf); end
      n_cmp++;
      if (!stable) begin n_bad++; $display("FAIL conv(%0d) bcd_hold: got unstable want %h", v, exp_bcd); end
   endtask

   task automatic test_reset();
      int done_seen;
      rst = 1'b0; in_start = 1'b0; in_bin = '0; in_start2 = 1'b0; in_bin2 = '0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bcd, busy, done, ovf} !== 15'd0) begin
         n_bad++; $display("FAIL reset_init: got %h want 0", {bcd, busy, done, ovf});
      end
      n_cmp++;
      if ({bcd2, busy2, done2, ovf2} !== 11'd0) begin
         n_bad++; $display("FAIL reset_init2: got %h want 0", {bcd2, busy2, done2, ovf2});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      convert1(8'd255, 0);
      // Abort a conversion mid-shift.
      @(negedge clk);
      in_start = 1'b1; in_bin = 8'd99;
      @(negedge clk);
      in_start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bcd, busy, done, ovf} !== 15'd0) begin
         n_bad++; $display("FAIL reset_async: got %h want 0", {bcd, busy, done, ovf});
      end
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      n_cmp++;
      if (done_seen !== 0) begin n_bad++; $display("FAIL reset_abort: got %0d activity cycles want 0", done_seen); end
      convert1(8'd42, 0);
   endtask

   task automatic test_edges();
      convert1(8'd0, 0);
      convert1(8'd9, 0);
      convert1(8'd100, 0);
      convert1(8'd255, 3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         convert1(8'($urandom_range(0, 255)), 0);
      end
   endtask

   task automatic run2(input logic [7:0] v);
      int k;
      logic [19:0] e20;
      e20 = ref_bcd(v, 2);
      @(negedge clk);
      in_start2 = 1'b1; in_bin2 = v;
      @(negedge clk);
      in_start2 = 1'b0;
      k = 0;
      while (!done2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (!done2) begin
         n_bad++; $display("FAIL ovf(%0d) timeout: got no done want done", v);
      end else begin
         n_cmp++;
         if (bcd2 !== e20[7:0]) begin n_bad++; $display("FAIL ovf(%0d) bcd: got %h want %h", v, bcd2, e20[7:0]); end
         n_cmp++;
         if (ovf2 !== (v > 8'd99)) begin n_bad++; $display("FAIL ovf(%0d) flag: got %b want %b", v, ovf2, (v > 8'd99)); end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_overflow();
      run2(8'd123);
      run2(8'd99);
      for (int i = 0; i < 5; i++) run2(8'($urandom_range(0, 255)));
   endtask

   task automatic test_back_to_back();
      logic [19:0] e1, e2;
      logic held_ok;
      int d1, d2;
      e1 = ref_bcd(17, 3);
      e2 = ref_bcd(200, 3);
      d1 = 0; d2 = 0; held_ok = 1'b1;
      @(negedge clk);
      in_start = 1'b1; in_bin = 8'd17;
      @(negedge clk);
      in_bin = 8'd200;
      for (int k = 1; k <= 24; k++) begin
         if (k > 1) @(negedge clk);
         if (done) begin
            if (d1 == 0) d1 = k; else if (d2 == 0) d2 = k;
         end
         if (d1 != 0 && d2 == 0 && bcd !== e1[11:0]) held_ok = 1'b0;
         if (k == 20) in_start = 1'b0;
      end
      n_cmp++;
      if (d1 !== 10) begin n_bad++; $display("FAIL b2b first_done: got %0d want 10", d1); end
      n_cmp++;
      if (d2 - d1 !== 10) begin n_bad++; $display("FAIL b2b period: got %0d want 10", d2 - d1); end
      n_cmp++;
      if (!held_ok) begin n_bad++; $display("FAIL b2b first_bcd: got changed want %h", e1[11:0]); end
      n_cmp++;
      if (bcd !== e2[11:0]) begin n_bad++; $display("FAIL b2b second_bcd: got %h want %h", bcd, e2[11:0]); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b idle_after: got busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_edges();
      test_random();
      test_overflow();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
